// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and RV32 opcode constants (shared with the control decoder).
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry in-order FIFO of fetched {pc, instr} pairs; flush empties it in one cycle.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  fetch_entry_t i_push_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);

    fetch_entry_t r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_do_push;
    logic         w_do_pop;

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    // A full buffer still takes a push when the head leaves in the same cycle.
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited requests, in-order response buffer, redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN enables the sticky misaligned-redirect flag.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [6:0]  id_opcode,
    output logic        misalign_err
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [1:0]   r_outstanding;
    logic [1:0]   r_drop_cnt;
    logic [1:0]   w_drop_nxt;
    logic [1:0]   w_out_after_rsp;
    logic [1:0]   w_buf_count;
    logic         w_credit_ok;
    logic         w_accept;
    logic         w_push;
    logic         w_pop;
    logic [31:0]  w_rsp_pc;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_buf_head;

    assign w_out_after_rsp = (imem_rsp_valid && (r_outstanding != 2'd0)) ?
                             (r_outstanding - 2'd1) : r_outstanding;
    assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, w_buf_count}) < 3'd2;
    assign w_accept    = imem_req_valid && imem_req_ready;

    // Outstanding requests in FETCH are consecutive words ending at r_pc-4,
    // so the oldest one (the one answering now) is recovered arithmetically.
    assign w_rsp_pc     = r_pc - {28'd0, r_outstanding, 2'b00};
    assign w_push_entry = '{pc: w_rsp_pc, instr: imem_rsp_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= BOOT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        imem_req_valid = 1'b0;
        w_push         = 1'b0;
        w_drop_nxt     = r_drop_cnt;
        case (r_state)
            BOOT: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                if (redirect_valid) begin
                    w_drop_nxt  = w_out_after_rsp;
                    w_state_nxt = (w_out_after_rsp != 2'd0) ? FLUSH : FETCH;
                end else begin
                    imem_req_valid = w_credit_ok;
                    w_push         = imem_rsp_valid;
                end
            end
            FLUSH: begin
                if (redirect_valid) begin
                    w_drop_nxt = w_out_after_rsp;
                end else begin
                    if (imem_rsp_valid && (r_drop_cnt != 2'd0)) w_drop_nxt = r_drop_cnt - 2'd1;
                    if (w_drop_nxt == 2'd0) w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            if (redirect_valid)  r_pc <= word_align(redirect_pc);
            else if (w_accept)   r_pc <= r_pc + 32'd4;
            r_outstanding <= w_out_after_rsp + {1'b0, w_accept};
            r_drop_cnt    <= w_drop_nxt;
        end
    end

    assign imem_req_addr = r_pc;
    assign w_pop         = id_valid && id_ready;

    fetch_buf u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_head      (w_buf_head),
        .o_count     (w_buf_count)
    );

    assign id_valid  = (w_buf_count != 2'd0);
    assign id_instr  = id_valid ? w_buf_head.instr : NOP_INSTR;
    assign id_pc     = id_valid ? w_buf_head.pc : '0;
    assign id_opcode = id_instr[6:0];

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          r_misalign <= 1'b0;
        else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) r_misalign <= 1'b1;
    end

    assign misalign_err = r_misalign;
`else
    assign misalign_err = 1'b0;
`endif

endmodule
